// File: rtl/m72_irq_pkg.sv
// Shared types and constants for the M72 raster/vblank interrupt scheduler.
package m72_irq_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_WR_LO = 2'd1,
        CFG_WR_HI = 2'd2
    } cfg_state_t;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_ACK1 = 2'd1,
        IRQ_ACK2 = 2'd2
    } irq_state_t;

    // Interrupt source bit positions in pending/mask/clear vectors
    localparam int SRC_RAS = 0;
    localparam int SRC_VBL = 1;

    localparam logic [1:0] ADDR_LINE_LO = 2'd0;
    localparam logic [1:0] ADDR_LINE_HI = 2'd1;
    localparam logic [1:0] ADDR_CLR     = 2'd2;
    localparam logic [1:0] ADDR_MASK    = 2'd3;

endpackage

// File: rtl/m72_irq_edge_latch.sv
// One interrupt source: rising-edge detect sampled on the pixel enable, feeding a
// sticky pending bit. A new edge beats a clear arriving in the same cycle.
module m72_irq_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic sig,
    input  logic clr,
    output logic pending
);

    logic sig_prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_prev_reg <= 1'b0;
            pending      <= 1'b0;
        end else begin
            if (ce) begin
                sig_prev_reg <= sig;
            end
            if (ce && sig && !sig_prev_reg) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/m72_irq_scheduler.sv
// M72 interrupt scheduler: deferred raster-line config writes plus prioritised
// VBL/RAS interrupt with two-pulse INTA. Define M72_IRQ_MASK_EN for a writable mask.
module m72_irq_scheduler
    import m72_irq_pkg::*;
#(
    parameter logic [7:0] VBL_VECTOR = 8'h20,
    parameter logic [7:0] RAS_VECTOR = 8'h22,
    parameter int          INTA_TMO   = 64
) (
    input  logic        CLK_32M,
    input  logic        RESET,
    input  logic        CE_PIX,
    input  logic        CPU_WR,
    input  logic [1:0]  CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    input  logic        HINT,
    input  logic        VBLK,
    output logic [15:0] TMG_D,
    output logic        TMG_A0,
    output logic        TMG_ISET,
    output logic        INT_REQ,
    input  logic        INTA,
    output logic [7:0]  INT_VECTOR,
    output logic        CFG_BUSY
);

    localparam int TMO_W = $clog2(INTA_TMO);

    logic            wr_line_lo, wr_line_hi, wr_clr;
    logic [8:0]      shadow_reg;
    logic            dirty_reg, immed_reg;
    cfg_state_t      cfg_state_reg;
    irq_state_t      irq_state_reg;
    logic            winner_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [1:0]      src_sig, pending, clr, mask, eff;
    logic            unused_din;

    assign wr_line_lo = CPU_WR && (CPU_ADDR == ADDR_LINE_LO);
    assign wr_line_hi = CPU_WR && (CPU_ADDR == ADDR_LINE_HI);
    assign wr_clr     = CPU_WR && (CPU_ADDR == ADDR_CLR);
    assign unused_din = ^CPU_DIN[14:8];

`ifdef M72_IRQ_MASK_EN
    logic [1:0] mask_reg;
    always_ff @(posedge CLK_32M or posedge RESET) begin
        if (RESET) begin
            mask_reg <= 2'b11;
        end else if (CPU_WR && (CPU_ADDR == ADDR_MASK)) begin
            mask_reg <= CPU_DIN[1:0];
        end
    end
    assign mask = mask_reg;
`else
    assign mask = 2'b11;
`endif

    assign CFG_BUSY = dirty_reg || (cfg_state_reg != CFG_IDLE);

    // Line writes are held in the shadow until vblank (or an immediate request) makes them safe
    always_ff @(posedge CLK_32M or posedge RESET) begin
        if (RESET) begin
            shadow_reg    <= 9'h000;
            dirty_reg     <= 1'b0;
            immed_reg     <= 1'b0;
            cfg_state_reg <= CFG_IDLE;
            TMG_D         <= 16'h0000;
            TMG_A0        <= 1'b0;
            TMG_ISET      <= 1'b0;
        end else begin
            TMG_D    <= 16'h0000;
            TMG_A0   <= 1'b0;
            TMG_ISET <= 1'b0;
            case (cfg_state_reg)
                CFG_IDLE: begin
                    if (dirty_reg && (VBLK || immed_reg)) begin
                        cfg_state_reg <= CFG_WR_LO;
                        TMG_ISET      <= 1'b1;
                        TMG_D         <= {8'h00, shadow_reg[7:0]};
                        dirty_reg     <= 1'b0;
                        immed_reg     <= 1'b0;
                    end
                end
                CFG_WR_LO: begin
                    cfg_state_reg <= CFG_WR_HI;
                    TMG_ISET      <= 1'b1;
                    TMG_A0        <= 1'b1;
                    TMG_D         <= {15'b0, shadow_reg[8]};
                end
                default: cfg_state_reg <= CFG_IDLE;
            endcase
            // A CPU write lands after the FSM so a coincident one re-arms dirty
            if (wr_line_lo) begin
                shadow_reg[7:0] <= CPU_DIN[7:0];
                dirty_reg       <= 1'b1;
            end
            if (wr_line_hi) begin
                shadow_reg[8] <= CPU_DIN[0];
                dirty_reg     <= 1'b1;
                if (CPU_DIN[15]) begin
                    immed_reg <= 1'b1;
                end
            end
        end
    end

    assign src_sig = {VBLK, HINT};
    assign eff     = pending & mask;

    always_comb begin
        clr = 2'b00;
        if (wr_clr) begin
            clr = CPU_DIN[1:0];
        end
        if ((irq_state_reg == IRQ_ACK1) && INTA) begin
            clr[winner_reg] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            m72_irq_edge_latch u_latch (
                .clk     (CLK_32M),
                .rst     (RESET),
                .ce      (CE_PIX),
                .sig     (src_sig[gi]),
                .clr     (clr[gi]),
                .pending (pending[gi])
            );
        end
    endgenerate

    // INT_REQ is only raised while the handshake FSM sits (or is returning) in IDLE
    always_ff @(posedge CLK_32M or posedge RESET) begin
        if (RESET) begin
            irq_state_reg <= IRQ_IDLE;
            winner_reg    <= 1'b0;
            tmo_cnt_reg   <= '0;
            INT_VECTOR    <= 8'h00;
            INT_REQ       <= 1'b0;
        end else begin
            INT_REQ <= 1'b0;
            if (INTA) begin
                INT_VECTOR <= 8'h00;
            end
            case (irq_state_reg)
                IRQ_IDLE: begin
                    if (INTA && (eff != 2'b00)) begin
                        irq_state_reg <= IRQ_ACK1;
                        winner_reg    <= eff[SRC_VBL];
                        tmo_cnt_reg   <= '0;
                    end else begin
                        INT_REQ <= (eff != 2'b00);
                    end
                end
                IRQ_ACK1: begin
                    if (INTA) begin
                        irq_state_reg <= IRQ_ACK2;
                        INT_VECTOR    <= winner_reg ? VBL_VECTOR : RAS_VECTOR;
                    end else if (tmo_cnt_reg == TMO_W'(INTA_TMO - 1)) begin
                        irq_state_reg <= IRQ_IDLE;
                        INT_REQ       <= (eff != 2'b00);
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                IRQ_ACK2: begin
                    irq_state_reg <= IRQ_IDLE;
                    INT_REQ       <= (eff != 2'b00);
                end
                default: irq_state_reg <= IRQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m72_irq_scheduler.sv
// Randomised + directed bench for m72_irq_scheduler against a cycle-level behavioural model.
module tb_m72_irq_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_pix, cpu_wr, hint_s, vblk, inta;
    logic [1:0]  cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] tmg_d;
    logic        tmg_a0, tmg_iset, int_req, cfg_busy;
    logic [7:0]  int_vector;

    always #5 clk = ~clk;

    m72_irq_scheduler dut (
        .CLK_32M    (clk),
        .RESET      (rst),
        .CE_PIX     (ce_pix),
        .CPU_WR     (cpu_wr),
        .CPU_ADDR   (cpu_addr),
        .CPU_DIN    (cpu_din),
        .HINT       (hint_s),
        .VBLK       (vblk),
        .TMG_D      (tmg_d),
        .TMG_A0     (tmg_a0),
        .TMG_ISET   (tmg_iset),
        .INT_REQ    (int_req),
        .INTA       (inta),
        .INT_VECTOR (int_vector),
        .CFG_BUSY   (cfg_busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int edge_no = 0;
    bit cur_hint = 1'b0;
    bit cur_vblk = 1'b0;

    // Behavioural model state
    bit [8:0]  m_line;
    bit        m_dirty, m_immed;
    int        m_cfg_phase;      // cycles into the two-write config burst, 0 = none
    bit [1:0]  m_pend, m_mask;
    bit        m_prev_h, m_prev_v;
    int        m_ack_stage;      // 0 idle, 1 waiting for 2nd INTA, 2 vector cycle
    bit        m_winner_vbl;
    int        m_ack_start;
    bit [15:0] e_d;
    bit        e_a0, e_iset, e_req, e_busy;
    bit [7:0]  e_vec;

    task automatic model_reset();
        m_line = 9'h000; m_dirty = 0; m_immed = 0; m_cfg_phase = 0;
        m_pend = 2'b00; m_mask = 2'b11; m_prev_h = 0; m_prev_v = 0;
        m_ack_stage = 0; m_winner_vbl = 0; m_ack_start = 0;
        e_d = 16'h0; e_a0 = 0; e_iset = 0; e_req = 0; e_busy = 0; e_vec = 8'h00;
    endtask

    // Advance the model across one rising edge with the given inputs
    task automatic model_edge(input bit c, input bit w, input bit [1:0] a,
                              input bit [15:0] dn, input bit h, input bit v, input bit ia);
        bit [1:0] rise, req_src, clr;
        edge_no++;
        req_src = m_pend & m_mask;

        e_d = 16'h0; e_a0 = 0; e_iset = 0;
        if (m_cfg_phase == 0 && m_dirty && (v || m_immed)) begin
            m_cfg_phase = 1; e_iset = 1; e_d = {8'h00, m_line[7:0]};
            m_dirty = 0; m_immed = 0;
        end else if (m_cfg_phase == 1) begin
            m_cfg_phase = 2; e_iset = 1; e_a0 = 1; e_d = {15'b0, m_line[8]};
        end else begin
            m_cfg_phase = 0;
        end

        rise = 2'b00;
        if (c) begin
            rise[0] = h && !m_prev_h;
            rise[1] = v && !m_prev_v;
            m_prev_h = h;
            m_prev_v = v;
        end
        clr = (w && a == 2'd2) ? dn[1:0] : 2'b00;
        if (ia) e_vec = 8'h00;
        if (m_ack_stage == 0) begin
            if (ia && req_src != 2'b00) begin
                m_ack_stage = 1; m_winner_vbl = req_src[1]; m_ack_start = edge_no;
            end
        end else if (m_ack_stage == 1) begin
            if (ia) begin
                m_ack_stage = 2;
                e_vec = m_winner_vbl ? 8'h20 : 8'h22;
                clr[m_winner_vbl] = 1'b1;
                $display("ack: vector %02h delivered at edge %0d", e_vec, edge_no);
            end else if (edge_no - m_ack_start == 64) begin
                m_ack_stage = 0;
            end
        end else begin
            m_ack_stage = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        e_req = (req_src != 2'b00) && (m_ack_stage == 0);

        if (w && a == 2'd0) begin
            m_line[7:0] = dn[7:0]; m_dirty = 1;
        end
        if (w && a == 2'd1) begin
            m_line[8] = dn[0]; m_dirty = 1;
            if (dn[15]) m_immed = 1;
        end
`ifdef M72_IRQ_MASK_EN
        if (w && a == 2'd3) m_mask = dn[1:0];
`endif
        e_busy = m_dirty || (m_cfg_phase != 0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_no, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("TMG_D", tmg_d, e_d);
        chk("TMG_A0", {15'b0, tmg_a0}, {15'b0, e_a0});
        chk("TMG_ISET", {15'b0, tmg_iset}, {15'b0, e_iset});
        chk("INT_REQ", {15'b0, int_req}, {15'b0, e_req});
        chk("INT_VECTOR", {8'h00, int_vector}, {8'h00, e_vec});
        chk("CFG_BUSY", {15'b0, cfg_busy}, {15'b0, e_busy});
    endtask

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge
    task automatic step(input bit c, input bit w, input bit [1:0] a, input bit [15:0] dn, input bit ia);
        ce_pix = c; cpu_wr = w; cpu_addr = a; cpu_din = dn;
        hint_s = cur_hint; vblk = cur_vblk; inta = ia;
        model_edge(c, w, a, dn, cur_hint, cur_vblk, ia);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 16'h0, 0);
    endtask
    task automatic wr(input bit [1:0] a, input bit [15:0] dn);
        step(0, 1, a, dn, 0);
    endtask
    task automatic sample();
        step(1, 0, 2'd0, 16'h0, 0);
    endtask
    task automatic ack();
        step(0, 0, 2'd0, 16'h0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_D"}, tmg_d, 16'h0);
        chk({tag, "_A0"}, {15'b0, tmg_a0}, 16'h0);
        chk({tag, "_ISET"}, {15'b0, tmg_iset}, 16'h0);
        chk({tag, "_REQ"}, {15'b0, int_req}, 16'h0);
        chk({tag, "_VEC"}, {8'h00, int_vector}, 16'h0);
        chk({tag, "_BUSY"}, {15'b0, cfg_busy}, 16'h0);
    endtask

    initial begin
        rst = 1'b1; ce_pix = 0; cpu_wr = 0; cpu_addr = 0; cpu_din = 0;
        hint_s = 0; vblk = 0; inta = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Deferred line write committed at vblank
        wr(2'd0, 16'h00F5); wr(2'd1, 16'h0000); idle(3);
        chk("t1_no_iset", {15'b0, tmg_iset}, 16'h0);
        chk("t1_busy", {15'b0, cfg_busy}, 16'h1);
        cur_vblk = 1; idle(1);
        chk("t1_lo_iset", {15'b0, tmg_iset}, 16'h1);
        chk("t1_lo_a0", {15'b0, tmg_a0}, 16'h0);
        chk("t1_lo_d", tmg_d, 16'h00F5);
        idle(1);
        chk("t1_hi_a0", {15'b0, tmg_a0}, 16'h1);
        chk("t1_hi_d", tmg_d, 16'h0000);
        idle(1);
        chk("t1_done_iset", {15'b0, tmg_iset}, 16'h0);
        chk("t1_done_busy", {15'b0, cfg_busy}, 16'h0);
        cur_vblk = 0; sample();

        // Immediate line write mid-frame
        wr(2'd1, 16'h8001);
        chk("t2_busy", {15'b0, cfg_busy}, 16'h1);
        idle(1);
        chk("t2_lo_d", tmg_d, 16'h00F5);
        idle(1);
        chk("t2_hi_a0", {15'b0, tmg_a0}, 16'h1);
        chk("t2_hi_d", tmg_d, 16'h0001);
        idle(1);

        // Raster interrupt handshake
        cur_hint = 1; sample(); idle(1);
        chk("t3_req", {15'b0, int_req}, 16'h1);
        ack();
        chk("t3_req_ack1", {15'b0, int_req}, 16'h0);
        ack();
        chk("t3_vec", {8'h00, int_vector}, 16'h0022);
        idle(1);
        chk("t3_req_after", {15'b0, int_req}, 16'h0);
        cur_hint = 0; sample();

        // Simultaneous sources: vblank first, raster next
        cur_hint = 1; cur_vblk = 1; sample(); idle(1);
        ack(); ack();
        chk("t4_vec1", {8'h00, int_vector}, 16'h0020);
        idle(1);
        chk("t4_req_again", {15'b0, int_req}, 16'h1);
        ack(); ack();
        chk("t4_vec2", {8'h00, int_vector}, 16'h0022);
        idle(1);
        chk("t4_req_end", {15'b0, int_req}, 16'h0);
        cur_hint = 0; cur_vblk = 0; sample();

        // Set beats a same-cycle clear
        cur_hint = 1; step(1, 1, 2'd2, 16'h0001, 0); idle(1);
        chk("setwins_req", {15'b0, int_req}, 16'h1);
        wr(2'd2, 16'h0001); idle(1);
        chk("clr_req", {15'b0, int_req}, 16'h0);
        cur_hint = 0; sample();

        // INTA timeout, then reset in the middle of ACK1
        cur_hint = 1; sample(); idle(1); ack(); idle(63);
        chk("t5_req_waiting", {15'b0, int_req}, 16'h0);
        idle(1);
        chk("t5_req_timeout", {15'b0, int_req}, 16'h1);
        ack(); wr(2'd0, 16'h0012); idle(1);
        #2 rst = 1'b1;
        #1 check_all_zero("t5_rst");
        model_reset();
        cur_hint = 0; hint_s = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Mask register
        wr(2'd3, 16'h0002);
        cur_hint = 1; sample(); idle(2);
`ifdef M72_IRQ_MASK_EN
        chk("t6_masked", {15'b0, int_req}, 16'h0);
        wr(2'd3, 16'h0003); idle(1);
        chk("t6_unmasked", {15'b0, int_req}, 16'h1);
`else
        chk("t6_nomask", {15'b0, int_req}, 16'h1);
`endif
        cur_hint = 0; sample(); wr(2'd2, 16'h0003); idle(2);

        // Random traffic with varying acknowledge density
        for (int i = 0; i < 3000; i++) begin
            bit        c, w, ia;
            bit [1:0]  a;
            bit [15:0] dn;
            int        ia_div;
            ia_div = (i < 1000) ? 3 : ((i < 2000) ? 12 : 40);
            c  = $urandom_range(0, 1) == 1;
            w  = $urandom_range(0, 5) == 0;
            a  = 2'($urandom_range(0, 3));
            dn = 16'($urandom);
            ia = $urandom_range(0, ia_div - 1) == 0;
            if ($urandom_range(0, 7) == 0)  cur_hint = !cur_hint;
            if ($urandom_range(0, 31) == 0) cur_vblk = !cur_vblk;
            step(c, w, a, dn, ia);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
